if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the immediate-extension unit (Cloud).
//  Owns the PC, fetches one word at a time from instruction memory over a req/ack handshake,
//  and holds it in the IF/ID register until decode consumes it.
//  Splits the held word into opcode[31:26] and cloud_instr[15:0] for Cloud; takes Cloud's
//  32-bit immediate back as the branch offset.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC value after reset; must be word aligned
//  MAX_WAIT  15             cycles in REQ without imem_ack before timeout (1..255)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  stall        in   1   decode not ready; held word is not consumed
//  pc_sel       in   1   1 = branch taken for the word being consumed
//  branch_imm   in   32  byte offset from Cloud (sign-extended, already shifted)
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address (= pc_out)
//  imem_ack     in   1   rdata valid this cycle; ignored unless imem_req=1
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  IF/ID instruction register
//  opcode       out  6   instr[31:26]
//  cloud_instr  out  16  instr[15:0]
//  pc_out       out  32  address of the held / in-flight word
//  instr_valid  out  1   instr holds an unconsumed word
//  fetch_timeout out 1   sticky; MAX_WAIT exceeded
// BEHAVIOUR
//  - Reset is synchronous and active-high and dominates every other input.
//    After reset: pc_out=PC_RESET, instr=0, instr_valid=0, imem_req=0, fetch_timeout=0,
//    wait counter=0, state=IDLE.
//  - FSM states: IDLE, REQ, VALID, ERR.
//    - IDLE: always moves to REQ on the next cycle.
//    - REQ: imem_req=1 and imem_addr=pc_out, both held stable until ack.
//      On ack: instr<=imem_rdata, instr_valid<=1, go to VALID; imem_req drops on the same edge.
//      With no ack, the counter increments; when counter==MAX_WAIT-1 with no ack:
//      go to ERR and set fetch_timeout.
//    - VALID: a word is consumed on any cycle with stall=0.
//      On consume: pc_out<=pc_sel ? pc_out+4+branch_imm : pc_out+4; instr_valid<=0; go to REQ.
//      With stall=1: instr, pc_out and state are held; pc_sel and branch_imm are ignored.
//    - ERR: imem_req=0; state is terminal until reset; instr_valid=0.
//  - Latency: ack to instr_valid is 1 cycle; minimum issue rate is one word per 2 cycles.
//  - Address arithmetic: all PC arithmetic is modulo 2^32
//    (32'hFFFF_FFFC + 4 = 32'h0000_0000). Next-PC bits [1:0] are forced to 2'b00.
//  - An ack while not in REQ is ignored. An ack in the same cycle as reset is ignored.
//  - Reset mid-fetch: imem_req=0 from the next cycle; the pending word is discarded.
//  - opcode and cloud_instr are pure slices of instr (no added latency).
// CONFIGURATION
//  FETCH_CNT_EN defined:
//   - Adds output port fetch_count[31:0] (reset 0).
//   - fetch_count increments by 1 on each consume and wraps at 2^32.
//  FETCH_CNT_EN undefined:
//   - The port and the counter do not exist; all other behaviour is identical.
// TESTING
//  - Reset, then ack=1 with rdata=32'hE0FF_FF00 in the first REQ cycle
//    -> imem_addr=0; next cycle instr_valid=1, opcode=6'b111000, cloud_instr=16'hFF00.
//  - VALID, stall=1 for 3 cycles, then stall=0 with pc_sel=0
//    -> instr held for 3 cycles; pc_out 0->4; imem_req=1 on the following cycle.
//  - pc_out=32'h40, consume with pc_sel=1, branch_imm=32'hFFFF_FFF0
//    -> pc_out=32'h34; with branch_imm=32'h6 -> pc_out=32'h48.
//  - PC_RESET=32'hFFFF_FFFC, consume with pc_sel=0 -> pc_out=32'h0.
//  - MAX_WAIT=4, no ack -> fetch_timeout=1 after 4 REQ cycles;
//    imem_req=0 thereafter; reset clears both.
//  - Reset asserted during REQ with ack in the same cycle
//    -> instr=0, instr_valid=0, pc_out=PC_RESET.
//    With FETCH_CNT_EN: 5 consumes -> fetch_count=5; reset -> 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word over imem req/ack, holds it in IF/ID.
// Latency: imem_ack -> instr_valid is 1 cycle; at best one word is issued every 2 cycles.
// Backpressure: stall=1 holds instr/pc_out/state; no new request is issued until the word is consumed.
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   stall               decode not ready; the held word is kept
//   pc_sel, branch_imm  branch taken / byte offset (from Cloud) for the word being consumed
//   imem_req/addr/ack/rdata  instruction memory handshake; addr always equals pc_out
//   instr, opcode, cloud_instr  IF/ID word and its slices [31:26] and [15:0]
//   pc_out              address of the held or in-flight word
//   instr_valid         instr holds an unconsumed word
//   fetch_timeout       sticky; memory failed to ack within MAX_WAIT request cycles
//   fetch_count         (only with FETCH_CNT_EN defined) number of consumed words, wraps at 2^32
//
// Optional feature macro: FETCH_CNT_EN adds the fetch_count output and its counter.

module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [31:0] branch_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [15:0] cloud_instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_timeout
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // MAX_WAIT is limited to 1..255, so an 8-bit wait counter always suffices.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] seq_pc;
  logic [31:0] tgt_pc;
  logic [31:0] next_pc;
  logic        consume;

  // Branch target is relative to the sequential PC (pc+4), all modulo 2^32.
  // The low two bits are cleared so an unaligned offset can never misalign the PC.
  assign seq_pc  = pc_out + 32'd4;
  assign tgt_pc  = seq_pc + branch_imm;
  assign next_pc = pc_sel ? {tgt_pc[31:2], 2'b00} : {seq_pc[31:2], 2'b00};

  assign consume = (state == S_VALID) && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pc_out        <= PC_RESET;
      instr         <= 32'h0;
      instr_valid   <= 1'b0;
      imem_req      <= 1'b0;
      fetch_timeout <= 1'b0;
      wait_cnt      <= 8'h0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          wait_cnt <= 8'h0;
        end

        S_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= 8'h0;
            state       <= S_VALID;
          end else if (wait_cnt == WAIT_LAST) begin
            // Memory never answered: park in ERR until reset.
            imem_req      <= 1'b0;
            fetch_timeout <= 1'b1;
            state         <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_VALID: begin
          // pc_sel/branch_imm only matter on the consuming cycle.
          if (consume) begin
            pc_out      <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            wait_cnt    <= 8'h0;
            state       <= S_REQ;
          end
        end

        S_ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
    end else if (consume) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

  // The request address is the PC itself, so it is stable for the whole REQ phase.
  assign imem_addr   = pc_out;
  assign opcode      = instr[31:26];
  assign cloud_instr = instr[15:0];

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [5:0]  opc;
    logic [15:0] cld;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: PC_RESET=0, MAX_WAIT=4
  logic        reset = 1'b1, stall = 1'b1, pc_sel = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_imm = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, instr_valid, fetch_timeout;
  logic [31:0] imem_addr, instr, pc_out;
  logic [5:0]  opcode;
  logic [15:0] cloud_instr;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  // DUT 1: PC_RESET=32'hFFFF_FFFC, MAX_WAIT default
  logic        reset1 = 1'b1, stall1 = 1'b1, pc_sel1 = 1'b0, ack1 = 1'b0;
  logic [31:0] imm1 = 32'h0, rdata1 = 32'h0;
  logic        req1, valid1, timeout1;
  logic [31:0] addr1, instr1, pc1;
  logic [5:0]  opcode1;
  logic [15:0] cloud1;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count1;
`endif

  if_fetch_stage #(.PC_RESET(32'h0), .MAX_WAIT(4)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .branch_imm(branch_imm),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .cloud_instr(cloud_instr), .pc_out(pc_out),
    .instr_valid(instr_valid), .fetch_timeout(fetch_timeout)
`ifdef FETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  if_fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset1), .stall(stall1), .pc_sel(pc_sel1), .branch_imm(imm1),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
    .instr(instr1), .opcode(opcode1), .cloud_instr(cloud1), .pc_out(pc1),
    .instr_valid(valid1), .fetch_timeout(timeout1)
`ifdef FETCH_CNT_EN
    , .fetch_count(fetch_count1)
`endif
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cons  = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new word presented by DUT 0 is matched against the oldest expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: word %h presented with nothing expected", instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_instr", instr, e.word);
        chk("sb_opcode", {26'h0, opcode}, {26'h0, e.opc});
        chk("sb_cloud", {16'h0, cloud_instr}, {16'h0, e.cld});
      end
    end
    prev_valid = instr_valid;
  end

  // Called at a negedge; waits (bounded) for a request, checks its address, acks it.
  task automatic fetch(input logic [31:0] w, input logic [31:0] exp_pc,
                       input logic [5:0] opc, input logic [15:0] cld);
    exp_t e;
    int   k;
    k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", {31'h0, imem_req}, 32'h1);
    chk("imem_addr", imem_addr, exp_pc);
    e.pc = exp_pc; e.word = w; e.opc = opc; e.cld = cld;
    exp_q.push_back(e);
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("valid_after_ack", {31'h0, instr_valid}, 32'h1);
    chk("req_drop_on_ack", {31'h0, imem_req}, 32'h0);
  endtask

  task automatic consume(input logic sel, input logic [31:0] imm, input logic [31:0] exp_pc);
    stall      = 1'b0;
    pc_sel     = sel;
    branch_imm = imm;
    @(negedge clk);
    stall      = 1'b1;
    pc_sel     = 1'b0;
    branch_imm = 32'h0;
    n_cons++;
    chk("consume_pc", pc_out, exp_pc);
    chk("consume_valid", {31'h0, instr_valid}, 32'h0);
    chk("consume_req", {31'h0, imem_req}, 32'h1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_timeout", {31'h0, fetch_timeout}, 32'h0);
`ifdef FETCH_CNT_EN
    chk("rst_fetch_count", fetch_count, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // First word: opcode 111000, cloud 16'hFF00.
    fetch(32'hE0FF_FF00, 32'h0, 6'b111000, 16'hFF00);

    // Three stalled cycles; a stray ack in VALID must be ignored.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      chk("stall_instr", instr, 32'hE0FF_FF00);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc", pc_out, 32'h0);
      chk("stall_req", {31'h0, imem_req}, 32'h0);
    end
    imem_rdata = 32'h0;
    consume(1'b0, 32'h0, 32'h4);

    // Branch arithmetic: 4+4+0x38=0x40; 0x40+4-16=0x34; 0x34+4+8=0x40; 0x40+4+6 -> 0x48.
    fetch(32'h1234_5678, 32'h4, 6'h04, 16'h5678);
    consume(1'b1, 32'h38, 32'h40);
    fetch(32'hFC00_0001, 32'h40, 6'h3F, 16'h0001);
    consume(1'b1, 32'hFFFF_FFF0, 32'h34);
    fetch(32'h0000_ABCD, 32'h34, 6'h00, 16'hABCD);
    consume(1'b1, 32'h8, 32'h40);
    fetch(32'h8421_0F0F, 32'h40, 6'h21, 16'h0F0F);
    consume(1'b1, 32'h6, 32'h48);
    fetch(32'h5555_AAAA, 32'h48, 6'h15, 16'hAAAA);
    consume(1'b0, 32'h6, 32'h4C);
`ifdef FETCH_CNT_EN
    chk("fetch_count", fetch_count, 32'd6);
`endif

    // Timeout: 4 REQ cycles with no ack, then ERR.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_req_hold", {31'h0, imem_req}, 32'h1);
      chk("to_not_yet", {31'h0, fetch_timeout}, 32'h0);
    end
    @(negedge clk);
    chk("to_set", {31'h0, fetch_timeout}, 32'h1);
    chk("to_req_drop", {31'h0, imem_req}, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("err_req", {31'h0, imem_req}, 32'h0);
      chk("err_timeout", {31'h0, fetch_timeout}, 32'h1);
      chk("err_valid", {31'h0, instr_valid}, 32'h0);
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    do_reset();

    // Reset with an ack in the same cycle during REQ.
    fetch(32'h0BAD_F00D, 32'h0, 6'h02, 16'hF00D);
    consume(1'b0, 32'h0, 32'h4);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
`ifdef FETCH_CNT_EN
    chk("midrst_fetch_count", fetch_count, 32'h0);
`endif
    reset = 1'b0;
    @(negedge clk);
    fetch(32'hC0DE_0042, 32'h0, 6'h30, 16'h0042);

    // DUT 1: PC wraps from 32'hFFFF_FFFC to 0.
    @(negedge clk);
    chk("d1_rst_pc", pc1, 32'hFFFF_FFFC);
    chk("d1_rst_req", {31'h0, req1}, 32'h0);
    reset1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("d1_req", {31'h0, req1}, 32'h1);
    chk("d1_addr", addr1, 32'hFFFF_FFFC);
    ack1   = 1'b1;
    rdata1 = 32'h2468_1357;
    @(negedge clk);
    ack1   = 1'b0;
    chk("d1_valid", {31'h0, valid1}, 32'h1);
    chk("d1_instr", instr1, 32'h2468_1357);
    stall1 = 1'b0;
    @(negedge clk);
    stall1 = 1'b1;
    chk("d1_wrap_pc", pc1, 32'h0);
    chk("d1_req_again", {31'h0, req1}, 32'h1);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
